// File: rtl/vmul_pkg.sv
// Shared definitions for the two-requester Vedic multiply/accumulate scheduler.
// Holds the default widths and the record that lives in the first pipeline
// stage between arbitration and the multiplier.
package vmul_pkg;

    localparam int VMUL_NREQ  = 2;
    localparam int VMUL_ACC_W = 20;
    localparam int OPW        = 8;
    localparam int PRODW      = 16;

    typedef struct packed {
        logic           valid;
        logic           id;
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           acc;
    } s1_t;

endpackage

// File: rtl/i8bit_mul.sv
// Combinational 8x8 unsigned Vedic (Urdhva Tiryagbhyam) multiplier core.
// Ports:
//   a_i, b_i : 8-bit operands
//   p_o      : 16-bit product
// The product is built recursively: 2x2 blocks from half adders, 4x4 from
// four 2x2 partials, 8x8 from four 4x4 partials.
module i8bit_mul (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    function automatic logic [3:0] vm2(input logic [1:0] a, input logic [1:0] b);
        logic t1, t2, t3, c1;
        t1  = a[1] & b[0];
        t2  = a[0] & b[1];
        t3  = a[1] & b[1];
        c1  = t1 & t2;
        vm2 = {t3 & c1, t3 ^ c1, t1 ^ t2, a[0] & b[0]};
    endfunction

    function automatic logic [7:0] vm4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] q0, q1, q2, q3;
        q0  = vm2(a[1:0], b[1:0]);
        q1  = vm2(a[3:2], b[1:0]);
        q2  = vm2(a[1:0], b[3:2]);
        q3  = vm2(a[3:2], b[3:2]);
        // q0 < 16, so the high and low partials concatenate without overlap.
        vm4 = {q3, q0} + ({4'b0, q1} << 2) + ({4'b0, q2} << 2);
    endfunction

    function automatic logic [15:0] vm8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q0, q1, q2, q3;
        q0  = vm4(a[3:0], b[3:0]);
        q1  = vm4(a[7:4], b[3:0]);
        q2  = vm4(a[3:0], b[7:4]);
        q3  = vm4(a[7:4], b[7:4]);
        vm8 = {q3, q0} + ({8'b0, q1} << 4) + ({8'b0, q2} << 4);
    endfunction

    assign p_o = vm8(a_i, b_i);

endmodule

// File: rtl/vmul_arbiter.sv
// Round-robin scheduler sharing one 8x8 Vedic multiplier between two
// requesters, with a per-requester multiply-accumulate register and a
// two-stage pipeline (operand stage S1, response stage S2).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : per-requester operand handshake
//   req_a/req_b           : packed operands, requester i in [8i+7:8i]
//   req_acc               : 1 = accumulate product, 0 = load product
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id/rsp_data       : owning requester and result value
module vmul_arbiter
    import vmul_pkg::*;
#(
    parameter int NREQ  = VMUL_NREQ,
    parameter int ACC_W = VMUL_ACC_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    input  logic [NREQ-1:0]     req_acc,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [ACC_W-1:0]    rsp_data
);

    s1_t              s1_q, s1_d;
    logic             ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [ACC_W-1:0] rsp_data_q, rsp_data_d;
    logic [ACC_W-1:0] acc_q [NREQ];
    logic [ACC_W-1:0] acc_d [NREQ];

    logic [NREQ-1:0]  grant;
    logic             gid;
    logic             accept;
    logic             s2_stall, s1_adv, s1_free;
    logic [PRODW-1:0] prod;
    logic [ACC_W-1:0] res;

    i8bit_mul u_mul (
        .a_i (s1_q.a),
        .b_i (s1_q.b),
        .p_o (prod)
    );

    assign s2_stall = rsp_valid_q & ~rsp_ready;
    assign s1_adv   = s1_q.valid & ~s2_stall;
    assign s1_free  = ~s1_q.valid | s1_adv;

    // ptr_q is the index that wins a tie; it moves away from whoever was
    // last accepted, so after reset requester 0 is favoured.
    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

    assign req_ready = grant & {NREQ{s1_free & rst_n}};
    assign accept    = |(req_valid & req_ready);
    assign gid       = grant[1];

    // Accumulator read and write both happen at the S1 advance, so
    // back-to-back accumulate ops from one requester chain without a hazard.
    assign res = s1_q.acc ? acc_q[s1_q.id] + ACC_W'(prod) : ACC_W'(prod);

    always_comb begin
        s1_d        = s1_q;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        acc_d       = acc_q;

        if (s1_adv) begin
            acc_d[s1_q.id] = res;
            rsp_valid_d    = 1'b1;
            rsp_id_d       = s1_q.id;
            rsp_data_d     = res;
            s1_d.valid     = 1'b0;
        end else if (!s2_stall) begin
            rsp_valid_d = 1'b0;
        end

        // A new accept overrides the vacated S1 in the same cycle.
        if (accept) begin
            s1_d.valid = 1'b1;
            s1_d.id    = gid;
            s1_d.a     = gid ? req_a[2*OPW-1:OPW] : req_a[OPW-1:0];
            s1_d.b     = gid ? req_b[2*OPW-1:OPW] : req_b[OPW-1:0];
            s1_d.acc   = req_acc[gid];
            ptr_d      = ~gid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q        <= '0;
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            acc_q       <= '{default: '0};
        end else begin
            s1_q        <= s1_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            acc_q       <= acc_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_vmul_arbiter.sv
module tb_vmul_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  req_acc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [19:0] rsp_data;

    vmul_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_acc   (req_acc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ordered list of ops in flight, each tagged with
    // whether it has reached the response stage. Results are computed at
    // accept time from a per-requester running sum.
    typedef struct {
        bit          id;
        int unsigned data;
        bit          in_s2;
    } ent_t;

    ent_t        q[$];
    int unsigned accm[2];
    bit          fav;
    int unsigned seen_d[$];
    bit          seen_id[$];
    int          n_cmp;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rn, input bit [1:0] v, input bit [7:0] a0, input bit [7:0] b0,
                         input bit c0, input bit [7:0] a1, input bit [7:0] b1, input bit c1,
                         input bit rr);
        rst_n     = rn;
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_acc   = {c1, c0};
        rsp_ready = rr;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            bit [1:0]    g;
            bit [1:0]    exp_rdy;
            bit          has_s1, head_s2, stall, s1free;
            bit          id;
            int unsigned p, d;
            @(negedge clk);
            if (req_valid == 2'b11) g = fav ? 2'b10 : 2'b01;
            else g = req_valid;
            has_s1  = (q.size() > 0) && !q[q.size()-1].in_s2;
            head_s2 = (q.size() > 0) && q[0].in_s2;
            stall   = head_s2 && !rsp_ready;
            s1free  = !has_s1 || !stall;
            exp_rdy = rst_n ? (g & {2{s1free}}) : 2'b00;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(head_s2));
            if (head_s2) begin
                chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rsp_data", 32'(rsp_data), q[0].data);
            end
            if (rst_n && rsp_valid && rsp_ready) begin
                seen_d.push_back(32'(rsp_data));
                seen_id.push_back(rsp_id);
            end
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                accm[0] = 0;
                accm[1] = 0;
                fav = 1'b0;
            end else begin
                if (head_s2 && rsp_ready) void'(q.pop_front());
                if (has_s1 && !stall) q[q.size()-1].in_s2 = 1'b1;
                if ((req_valid & exp_rdy) != 2'b00) begin
                    id = exp_rdy[1];
                    p  = (id ? req_a[15:8] : req_a[7:0]) * (id ? req_b[15:8] : req_b[7:0]);
                    d  = req_acc[id] ? ((accm[id] + p) % (1 << 20)) : p;
                    accm[id] = d;
                    q.push_back('{id: id, data: d, in_s2: 1'b0});
                    fav = ~id;
                end
            end
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        fav   = 1'b0;
        accm[0] = 0;
        accm[1] = 0;

        // reset
        drive(0, 2'b11, 1, 1, 0, 1, 1, 0, 1);
        step(2);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_data", 32'(rsp_data), 0);

        // single op, two-edge latency
        drive(1, 2'b01, 12, 13, 0, 0, 0, 0, 1);
        step(1);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        step(1);
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_id", 32'(rsp_id), 0);
        chk("single_data", 32'(rsp_data), 156);
        step(1);
        chk("single_done", 32'(rsp_valid), 0);

        // accumulate chain on requester 1
        seen_d.delete(); seen_id.delete();
        drive(1, 2'b10, 0, 0, 0, 255, 255, 0, 1); step(1);
        drive(1, 2'b10, 0, 0, 0, 2, 3, 1, 1);     step(1);
        drive(1, 2'b10, 0, 0, 0, 10, 10, 1, 1);   step(1);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1);     step(3);
        chk("chain_count", seen_d.size(), 3);
        if (seen_d.size() == 3) begin
            chk("chain_r0", seen_d[0], 65025);
            chk("chain_r1", seen_d[1], 65031);
            chk("chain_r2", seen_d[2], 65131);
            chk("chain_id", 32'({seen_id[0], seen_id[1], seen_id[2]}), 32'(3'b111));
        end

        // contention: both valid, grants alternate
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 0; step(1);
        seen_d.delete(); seen_id.delete();
        drive(1, 2'b11, 3, 4, 0, 5, 6, 0, 1); step(4);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1); step(3);
        chk("contend_count", seen_id.size(), 4);
        if (seen_id.size() == 4)
            chk("contend_ids", 32'({seen_id[0], seen_id[1], seen_id[2], seen_id[3]}), 32'(4'b0101));

        // backpressure: two ops in flight, then ready drops
        seen_d.delete(); seen_id.delete();
        drive(1, 2'b01, 7, 9, 0, 0, 0, 0, 0); step(5);
        chk("bp_ready_low", 32'(req_ready), 0);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1); step(3);
        chk("bp_count", seen_d.size(), 2);

        // wrap-around of the accumulator
        rst_n = 0; step(1);
        seen_d.delete(); seen_id.delete();
        drive(1, 2'b01, 255, 255, 1, 0, 0, 0, 1); step(17);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1);     step(3);
        chk("wrap_count", seen_d.size(), 17);
        if (seen_d.size() == 17)
            chk("wrap_final", seen_d[16], (17 * 65025) % (1 << 20));

        // mid-operation reset clears pipeline and accumulators
        drive(1, 2'b01, 5, 5, 1, 0, 0, 0, 0); step(2);
        rst_n = 0; step(1);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1); step(1);
        chk("midrst_valid", 32'(rsp_valid), 0);
        seen_d.delete(); seen_id.delete();
        drive(1, 2'b01, 1, 1, 1, 0, 0, 0, 1); step(1);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1); step(3);
        chk("midrst_count", seen_d.size(), 1);
        if (seen_d.size() == 1)
            chk("midrst_data", seen_d[0], 1);

        // randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(63) != 0),
                  2'($urandom_range(3)),
                  8'($urandom), 8'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom_range(9) < 7));
            step(1);
        end
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        step(4);
        chk("drain_empty", 32'(rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
